// File: rtl/cache_fill_arbiter_pkg.sv
// rtl/cache_fill_arbiter_pkg.sv - shared types and constants for the cache fill arbiter
package cache_fill_arbiter_pkg;

  localparam int          BLOCK_WORDS = 8;
  localparam int          OFF_W       = 3;
  localparam logic [15:0] BLOCK_MASK  = 16'hFFF0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/cache_fill_arbiter_word_counter.sv
// rtl/cache_fill_arbiter_word_counter.sv - block word counter with terminal-count flag
module word_counter
  import cache_fill_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [OFF_W-1:0] cnt,
  output logic             term
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign term = (cnt == OFF_W'(BLOCK_WORDS - 1));

endmodule

// File: rtl/cache_fill_arbiter.sv
// rtl/cache_fill_arbiter.sv - shares backing memory between I/D miss fills and D write-through
module cache_fill_arbiter
  import cache_fill_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_data_valid,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] fill_data,
  output logic [OFF_W-1:0]  fill_word,
  output logic              fill_we_i,
  output logic              fill_we_d,
  output logic              i_done,
  output logic              d_done,
  output logic              d_wr_done,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(~BLOCK_MASK);

  state_t             state, state_nxt;
  owner_t             owner;
  logic [ADDR_W-1:0]  base, wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic [OFF_W-1:0]   issue_cnt, rcv_cnt;
  logic               issue_term, rcv_term;
  logic               in_idle, receiving, fill, last;

  assign in_idle   = (state == IDLE);
  assign receiving = (state == ISSUE) || (state == WAIT);
  assign fill      = receiving && mem_data_valid;
  assign last      = fill && rcv_term;

  // Both counters sit at zero whenever the arbiter is idle, so every grant starts at word 0.
  word_counter u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (in_idle),
    .en    (state == ISSUE),
    .cnt   (issue_cnt),
    .term  (issue_term)
  );

  word_counter u_rcv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (in_idle),
    .en    (fill),
    .cnt   (rcv_cnt),
    .term  (rcv_term)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= OWN_I;
      base    <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state <= state_nxt;
      if (in_idle) begin
        if (d_miss) begin
          owner <= OWN_D;
          base  <= d_miss_addr & BASE_MASK;
        end else if (d_wr) begin
          wr_addr <= d_wr_addr;
          wr_data <= d_wr_data;
        end else if (i_miss) begin
          owner <= OWN_I;
          base  <= i_miss_addr & BASE_MASK;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (d_miss || i_miss) state_nxt = (!d_miss && d_wr) ? WRITE : ISSUE;
        else if (d_wr)        state_nxt = WRITE;
      end
      WRITE: state_nxt = IDLE;
      // The final return can coincide with the last issue when memory latency is short.
      ISSUE: begin
        if (last)            state_nxt = IDLE;
        else if (issue_term) state_nxt = WAIT;
      end
      WAIT: begin
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_en    = (state == WRITE) || (state == ISSUE);
  assign mem_wr    = (state == WRITE);
  assign mem_addr  = (state == WRITE) ? wr_addr :
                     (state == ISSUE) ? (base | ADDR_W'({issue_cnt, 1'b0})) : '0;
  assign mem_wdata = (state == WRITE) ? wr_data : '0;
  assign d_wr_done = (state == WRITE);
  assign fill_data = fill ? mem_data : '0;
  assign fill_word = fill ? rcv_cnt : '0;
  assign fill_we_i = fill && (owner == OWN_I);
  assign fill_we_d = fill && (owner == OWN_D);
  assign i_done    = last && (owner == OWN_I);
  assign d_done    = last && (owner == OWN_D);
  assign busy      = !in_idle;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// tb/tb_cache_fill_arbiter.sv - self-checking bench for cache_fill_arbiter
module tb_cache_fill_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_miss, d_miss, d_wr, mem_data_valid;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data, mem_data;
  logic        mem_en, mem_wr, fill_we_i, fill_we_d, i_done, d_done, d_wr_done, busy;
  logic [15:0] mem_addr, mem_wdata, fill_data;
  logic [2:0]  fill_word;

  always #5 clk = ~clk;

  cache_fill_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr(d_wr), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_data(mem_data), .mem_data_valid(mem_data_valid),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .fill_data(fill_data), .fill_word(fill_word),
    .fill_we_i(fill_we_i), .fill_we_d(fill_we_d),
    .i_done(i_done), .d_done(d_done), .d_wr_done(d_wr_done), .busy(busy)
  );

  typedef struct { logic [15:0] addr; logic own_d; } iss_t;
  typedef struct { logic own_d; logic [2:0] word; logic [15:0] data; } fill_t;
  typedef struct { int cyc; logic [15:0] data; } ret_t;
  typedef struct { logic [15:0] addr; logic [15:0] data; } wr_t;
  typedef struct {
    logic        kind_wr;
    logic        own_d;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp_base;
    int          exp_lat;
  } vec_t;

  iss_t  iss_q[$];
  fill_t fill_q[$];
  ret_t  ret_q[$];
  wr_t   wr_q[$];
  vec_t  vecs[5];

  int passed = 0, total = 0, cyc = 0;
  int iss_n, fill_n, i_done_n, d_done_n, wr_done_n, first_iss, first_fill, g;
  logic        inj = 1'b0;
  logic [15:0] inj_data = 16'h0;

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic monitor();
    iss_t  e;
    fill_t f;
    ret_t  r;
    wr_t   w;
    if (mem_en && !mem_wr) begin
      iss_n++;
      if (first_iss < 0) first_iss = cyc;
      if (iss_q.size() == 0) chk("spurious_issue", 64'(mem_addr), 64'hFFFF_FFFF);
      else begin
        e = iss_q.pop_front();
        chk("issue_addr", 64'(mem_addr), 64'(e.addr));
        r.cyc = cyc + 4; r.data = mem_val(e.addr);
        ret_q.push_back(r);
        f.own_d = e.own_d; f.word = e.addr[3:1]; f.data = mem_val(e.addr);
        fill_q.push_back(f);
      end
    end
    if (mem_en && mem_wr) begin
      if (wr_q.size() == 0) chk("spurious_write", 64'(mem_addr), 64'hFFFF_FFFF);
      else begin
        w = wr_q.pop_front();
        chk("write_addr", 64'(mem_addr), 64'(w.addr));
        chk("write_data", 64'(mem_wdata), 64'(w.data));
        chk("write_done_pulse", 64'(d_wr_done), 64'd1);
      end
    end
    if (fill_we_i || fill_we_d) begin
      fill_n++;
      if (first_fill < 0) first_fill = cyc;
      if (fill_q.size() == 0) chk("spurious_fill", 64'(fill_data), 64'hFFFF_FFFF);
      else begin
        f = fill_q.pop_front();
        chk("fill", 64'({fill_we_d, fill_we_i, fill_word, fill_data}),
            64'({f.own_d, !f.own_d, f.word, f.data}));
      end
    end
    if (i_done)    i_done_n++;
    if (d_done)    d_done_n++;
    if (d_wr_done) wr_done_n++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (ret_q.size() != 0 && ret_q[0].cyc == cyc) begin
      mem_data_valid = 1'b1;
      mem_data       = ret_q[0].data;
      void'(ret_q.pop_front());
    end else if (inj) begin
      mem_data_valid = 1'b1;
      mem_data       = inj_data;
      inj            = 1'b0;
    end else begin
      mem_data_valid = 1'b0;
      mem_data       = 16'h0;
    end
    @(negedge clk);
    monitor();
  endtask

  task automatic clear_counts();
    iss_n = 0; fill_n = 0; i_done_n = 0; d_done_n = 0; wr_done_n = 0;
    first_iss = -1; first_fill = -1;
  endtask

  task automatic push_block(input logic [15:0] base, input logic own_d);
    iss_t e;
    for (int w = 0; w < 8; w++) begin
      e.addr  = base | 16'(w << 1);
      e.own_d = own_d;
      iss_q.push_back(e);
    end
  endtask

  // which: 0 = i_done, 1 = d_done, 2 = d_wr_done
  task automatic wait_done(input int which, input string name);
    int  start;
    bit  seen;
    start = (which == 0) ? i_done_n : (which == 1) ? d_done_n : wr_done_n;
    seen  = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      step();
      seen = ((which == 0) ? i_done_n : (which == 1) ? d_done_n : wr_done_n) != start;
    end
    if (!seen) chk(name, 64'd0, 64'd1);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
                fill_we_i, fill_we_d, i_done, d_done, d_wr_done, busy});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 16'h1236, 16'h0000, 16'h1230, 12};
    vecs[1] = '{1'b0, 1'b1, 16'h345A, 16'h0000, 16'h3450, 12};
    vecs[2] = '{1'b1, 1'b1, 16'h2002, 16'hBEEF, 16'h2002, 1};
    vecs[3] = '{1'b0, 1'b0, 16'hFFFE, 16'h0000, 16'hFFF0, 12};
    vecs[4] = '{1'b0, 1'b1, 16'h000E, 16'h0000, 16'h0000, 12};

    rst_n = 1'b0; i_miss = 0; d_miss = 0; d_wr = 0;
    i_miss_addr = 0; d_miss_addr = 0; d_wr_addr = 0; d_wr_data = 0;
    mem_data = 0; mem_data_valid = 0;
    clear_counts();
    step(); step();
    chk("reset_outputs", all_outs(), 64'd0);
    rst_n = 1'b1;
    step();

    foreach (vecs[n]) begin
      clear_counts();
      g = cyc;
      if (vecs[n].kind_wr) begin
        wr_t w;
        d_wr = 1; d_wr_addr = vecs[n].addr; d_wr_data = vecs[n].data;
        w.addr = vecs[n].exp_base; w.data = vecs[n].data;
        wr_q.push_back(w);
        wait_done(2, "row_timeout");
        d_wr = 0;
        chk("row_latency", 64'(cyc - g), 64'(vecs[n].exp_lat));
        chk("row_no_issue", 64'(iss_n + fill_n + i_done_n + d_done_n), 64'd0);
      end else begin
        if (vecs[n].own_d) begin
          d_miss = 1; d_miss_addr = vecs[n].addr;
        end else begin
          i_miss = 1; i_miss_addr = vecs[n].addr;
        end
        push_block(vecs[n].exp_base, vecs[n].own_d);
        wait_done(vecs[n].own_d ? 1 : 0, "row_timeout");
        d_miss = 0; i_miss = 0;
        chk("row_latency", 64'(cyc - g), 64'(vecs[n].exp_lat));
        chk("row_first_issue", 64'(first_iss - g), 64'd1);
        chk("row_first_fill", 64'(first_fill - g), 64'd5);
        chk("row_counts", 64'({iss_n[7:0], fill_n[7:0]}), 64'h0808);
        chk("row_other_done", 64'(vecs[n].own_d ? i_done_n + wr_done_n : d_done_n + wr_done_n), 64'd0);
      end
      step();
      chk("row_idle_after", 64'(busy), 64'd0);
    end

    // Simultaneous I and D misses: D wins, I is served right after.
    clear_counts();
    g = cyc;
    i_miss = 1; i_miss_addr = 16'h0040;
    d_miss = 1; d_miss_addr = 16'h8008;
    push_block(16'h8000, 1'b1);
    push_block(16'h0040, 1'b0);
    wait_done(1, "both_d_timeout");
    d_miss = 0;
    chk("both_d_done_cycle", 64'(cyc - g), 64'd12);
    wait_done(0, "both_i_timeout");
    i_miss = 0;
    chk("both_i_done_cycle", 64'(cyc - g), 64'd25);
    chk("both_fill_count", 64'(fill_n), 64'd16);
    step();

    // Reset in the middle of an I fill with the request still held.
    clear_counts();
    g = cyc;
    i_miss = 1; i_miss_addr = 16'h5A5C;
    push_block(16'h5A50, 1'b0);
    while (cyc < g + 6) step();
    rst_n = 1'b0;
    iss_q.delete(); fill_q.delete(); ret_q.delete();
    step();
    chk("midrst_outputs", all_outs(), 64'd0);
    chk("midrst_no_done", 64'(i_done_n), 64'd0);
    chk("midrst_issues_before", 64'(iss_n), 64'd6);
    rst_n = 1'b1;
    clear_counts();
    g = cyc;
    push_block(16'h5A50, 1'b0);
    wait_done(0, "midrst_timeout");
    i_miss = 0;
    chk("midrst_restart_latency", 64'(cyc - g), 64'd12);
    chk("midrst_restart_issues", 64'(iss_n), 64'd8);
    step();

    // Request dropped partway through: the block still completes.
    clear_counts();
    g = cyc;
    i_miss = 1; i_miss_addr = 16'h0102;
    push_block(16'h0100, 1'b0);
    step(); step(); step();
    i_miss = 0;
    wait_done(0, "drop_timeout");
    chk("drop_done_cycle", 64'(cyc - g), 64'd12);
    chk("drop_fill_count", 64'(fill_n), 64'd8);
    step();

    // Stray valid while idle is ignored.
    inj = 1'b1; inj_data = 16'h1234;
    step();
    chk("idle_valid_no_fill", 64'({fill_we_i, fill_we_d, busy}), 64'd0);
    step();
    chk("idle_valid_stays_idle", 64'(busy), 64'd0);

    chk("scoreboard_drained", 64'(iss_q.size() + fill_q.size() + ret_q.size() + wr_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
